// File: rtl/sauria_mem_arbiter_if.sv
// Request/response and target-side bundle for sauria_mem_arbiter.
// Ports (signal names follow the original flat port list):
//   i_req/i_we/i_addr/i_wdata   per-requester request (2 requesters)
//   o_gnt/o_rvalid/o_rdata/o_err responses back to the requesters
//   o_tgt_sel/we/addr/wdata     one-hot target strobe and payload
//   i_tgt_rdata                 per-target read data (CFG, SRAMA, SRAMB, SRAMC)
// modport slave is the arbiter side; modport master is the requester/target side.
interface sauria_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          i_req;
  logic [1:0]          i_we;
  logic [2*ADDR_W-1:0] i_addr;
  logic [2*DATA_W-1:0] i_wdata;
  logic [1:0]          o_gnt;
  logic [1:0]          o_rvalid;
  logic [DATA_W-1:0]   o_rdata;
  logic                o_err;
  logic [3:0]          o_tgt_sel;
  logic                o_tgt_we;
  logic [15:0]         o_tgt_addr;
  logic [DATA_W-1:0]   o_tgt_wdata;
  logic [4*DATA_W-1:0] i_tgt_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_tgt_rdata,
    output o_gnt, o_rvalid, o_rdata, o_err,
    output o_tgt_sel, o_tgt_we, o_tgt_addr, o_tgt_wdata
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_tgt_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_err,
    input  o_tgt_sel, o_tgt_we, o_tgt_addr, o_tgt_wdata
  );
endinterface

// File: rtl/sauria_mem_arbiter.sv
// sauria_mem_arbiter: round-robin arbiter between the host config port (req 0)
// and the DMA engine (req 1) onto the CFG register file and SRAMA/B/C.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ports:
//   i_clk   clock
//   i_rstn  synchronous active-low reset
//   bus     sauria_mem_arbiter_if.slave (requests, responses, target strobe)
// Parameters: ADDR_W/DATA_W widths, RD_LAT target read latency (>=1).
module sauria_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  sauria_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q;     // requester granted most recently
  logic                owner_q;
  logic                we_q;
  logic [19:0]         addr_q;     // only addr[19:0] takes part in decode/offset
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                win;
  logic [1:0]          gnt;
  logic [3:0]          dec_sel;
  logic [1:0]          dec_idx;
  logic                dec_err;

  // Arbitration: a lone requester wins; on contention the one not granted last.
  always_comb begin
    win = 1'b0;
    unique case (bus.i_req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  // Grant is combinational in IDLE and held off while reset is asserted.
  assign gnt = (state_q == IDLE && i_rstn && |bus.i_req) ?
               (win ? 2'b10 : 2'b01) : 2'b00;

  // Address decode on the captured address; bits above 19 are ignored.
  always_comb begin
    dec_sel = '0;
    dec_idx = 2'd0;
    dec_err = 1'b0;
    if (addr_q[19:16] == 4'd0) begin
      if (addr_q[15:9] <= 7'd4) dec_sel = 4'b0001;
      else                      dec_err = 1'b1;
    end else if (addr_q[19:16] <= 4'd3) begin
      dec_idx = addr_q[17:16];
      dec_sel = 4'b0001 << addr_q[17:16];
    end else begin
      dec_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|gnt) state_d = ISSUE;
      ISSUE: state_d = dec_err ? RESP : WAIT;
      WAIT:  if (cnt_q == '0) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (|gnt) begin
          owner_q <= win;
          last_q  <= win;
          we_q    <= bus.i_we[win];
          addr_q  <= bus.i_addr[(win ? ADDR_W : 0) +: 20];
          wdata_q <= bus.i_wdata[(win ? DATA_W : 0) +: DATA_W];
          rdata_q <= '0;
        end
        ISSUE: cnt_q <= CNT_W'(RD_LAT - 1);
        WAIT: begin
          if (cnt_q == '0) begin
            // Writes wait the same latency but return zero data.
            rdata_q <= we_q ? '0 : bus.i_tgt_rdata[int'(dec_idx)*DATA_W +: DATA_W];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  wire strobe = (state_q == ISSUE) && !dec_err;
  wire resp   = (state_q == RESP);

  assign bus.o_gnt       = gnt;
  assign bus.o_tgt_sel   = strobe ? dec_sel : 4'b0000;
  assign bus.o_tgt_we    = strobe & we_q;
  assign bus.o_tgt_addr  = strobe ? addr_q[15:0] : 16'h0000;
  assign bus.o_tgt_wdata = strobe ? wdata_q : '0;
  assign bus.o_rvalid    = resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_err       = resp & dec_err;
  assign bus.o_rdata     = resp ? rdata_q : '0;

endmodule
